// File: rtl/gpio_irq_pkg.sv
// Shared constants for the GPIO interrupt controller: register byte offsets
// and the bus data width.
package gpio_irq_pkg;

  localparam int DATA_W = 32;

  localparam logic [4:0] GPIO_IRQ_IE    = 5'h00;
  localparam logic [4:0] GPIO_IRQ_RISE  = 5'h04;
  localparam logic [4:0] GPIO_IRQ_FALL  = 5'h08;
  localparam logic [4:0] GPIO_IRQ_PEND  = 5'h0C;
  localparam logic [4:0] GPIO_IRQ_LEVEL = 5'h10;

endpackage

// File: rtl/gpio_pin_filter.sv
// One GPIO pin: two-flop synchroniser, persistence glitch filter and
// single-cycle rise/fall pulses coincident with the filtered level update.
module gpio_pin_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = $clog2(FILT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

  logic             sync1_q, sync2_q;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any cycle where the synchronised level agrees with the filtered level
  // restarts the count, so only an unbroken run of FILT_LEN cycles is accepted.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    accept = 1'b0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_MAX) begin
        accept = 1'b1;
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign level_o = filt_q;
  assign rise_o  = accept & sync2_q;
  assign fall_o  = accept & ~sync2_q;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO interrupt controller: per-pin conditioning, edge-select and pending
// registers behind a single-cycle register bus, with a level interrupt output.
module gpio_irq_ctrl
  import gpio_irq_pkg::*;
#(
  parameter int NUM_PINS = 8,
  parameter int FILT_LEN = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_PINS-1:0] pin_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [4:0]          addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                ack_o,
  output logic                irq_o
);

  logic [NUM_PINS-1:0] ie_q, ie_d;
  logic [NUM_PINS-1:0] rise_q, rise_d;
  logic [NUM_PINS-1:0] fall_q, fall_d;
  logic [NUM_PINS-1:0] pend_q, pend_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ack_q;

  logic [NUM_PINS-1:0] level, riseEv, fallEv, setEv, clrMask;
  logic [4:0]          wordAddr;
  logic                unusedBits;

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    gpio_pin_filter #(.FILT_LEN(FILT_LEN)) u_filter (
      .clk    (clk),
      .rst_n  (rst_n),
      .pin_i  (pin_i[i]),
      .level_o(level[i]),
      .rise_o (riseEv[i]),
      .fall_o (fallEv[i])
    );
  end

  assign wordAddr   = {addr_i[4:2], 2'b00};
  assign setEv      = (riseEv & rise_q) | (fallEv & fall_q);
  assign unusedBits = ^{addr_i[1:0], wdata_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      pend_q  <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      ie_q    <= ie_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pend_q  <= pend_d;
      rdata_q <= rdata_d;
      ack_q   <= req_i;
    end
  end

  // Read data is captured from pre-update register values; a new edge event
  // is OR-ed in after the W1C mask so it survives a same-cycle clear.
  always_comb begin
    ie_d    = ie_q;
    rise_d  = rise_q;
    fall_d  = fall_q;
    clrMask = '0;
    rdata_d = '0;
    if (req_i && we_i) begin
      case (wordAddr)
        GPIO_IRQ_IE:   ie_d    = wdata_i[NUM_PINS-1:0];
        GPIO_IRQ_RISE: rise_d  = wdata_i[NUM_PINS-1:0];
        GPIO_IRQ_FALL: fall_d  = wdata_i[NUM_PINS-1:0];
        GPIO_IRQ_PEND: clrMask = wdata_i[NUM_PINS-1:0];
        default: ;
      endcase
    end else if (req_i) begin
      case (wordAddr)
        GPIO_IRQ_IE:    rdata_d[NUM_PINS-1:0] = ie_q;
        GPIO_IRQ_RISE:  rdata_d[NUM_PINS-1:0] = rise_q;
        GPIO_IRQ_FALL:  rdata_d[NUM_PINS-1:0] = fall_q;
        GPIO_IRQ_PEND:  rdata_d[NUM_PINS-1:0] = pend_q;
        GPIO_IRQ_LEVEL: rdata_d[NUM_PINS-1:0] = level;
        default: ;
      endcase
    end
    pend_d = (pend_q & ~clrMask) | setEv;
  end

  assign rdata_o = rdata_q;
  assign ack_o   = ack_q;
  assign irq_o   = |(pend_q & ie_q);

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Scoreboard bench for gpio_irq_ctrl: a cycle-level reference model queues the
// expected bus responses and a negedge monitor checks acks, read data and irq.
module tb_gpio_irq_ctrl;

  localparam int NP = 8;
  localparam int FL = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NP-1:0] pin_i;
  logic          req_i, we_i;
  logic [4:0]    addr_i;
  logic [31:0]   wdata_i;
  logic [31:0]   rdata_o;
  logic          ack_o, irq_o;

  int nChecks = 0;
  int nPass   = 0;
  int cyc     = 0;

  typedef struct {
    logic        we;
    logic [31:0] data;
    int          cyc;
  } expT;
  expT expQ[$];

  // Reference model state
  logic [NP-1:0] mIe, mRise, mFall, mPend, mFilt;
  logic [NP-1:0] hist[$];

  gpio_irq_ctrl #(.NUM_PINS(NP), .FILT_LEN(FL)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_i  (pin_i),
    .req_i  (req_i),
    .we_i   (we_i),
    .addr_i (addr_i),
    .wdata_i(wdata_i),
    .rdata_o(rdata_o),
    .ack_o  (ack_o),
    .irq_o  (irq_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Behavioural model: a pin's filtered level flips once the last FL
  // synchronised samples (pin_i delayed two edges) all disagree with it.
  always @(posedge clk) begin : model
    logic [NP-1:0] acc, setv, clr;
    logic [31:0]   rv;
    cyc++;
    if (!rst_n) begin
      mIe = '0; mRise = '0; mFall = '0; mPend = '0; mFilt = '0;
      hist.delete();
      for (int k = 0; k <= FL; k++) hist.push_back('0);
    end else begin
      rv = '0;
      if (req_i && !we_i) begin
        case (addr_i[4:2])
          3'd0: rv[NP-1:0] = mIe;
          3'd1: rv[NP-1:0] = mRise;
          3'd2: rv[NP-1:0] = mFall;
          3'd3: rv[NP-1:0] = mPend;
          3'd4: rv[NP-1:0] = mFilt;
          default: rv = '0;
        endcase
      end
      if (req_i) expQ.push_back('{we_i, rv, cyc});
      acc = '1;
      for (int k = 1; k <= FL; k++) acc = acc & (hist[k] ^ mFilt);
      setv = acc & ((~mFilt & mRise) | (mFilt & mFall));
      mFilt = mFilt ^ acc;
      clr = '0;
      if (req_i && we_i) begin
        case (addr_i[4:2])
          3'd0: mIe   = wdata_i[NP-1:0];
          3'd1: mRise = wdata_i[NP-1:0];
          3'd2: mFall = wdata_i[NP-1:0];
          3'd3: clr   = wdata_i[NP-1:0];
          default: ;
        endcase
      end
      mPend = (mPend & ~clr) | setv;
      hist.push_front(pin_i);
      void'(hist.pop_back());
    end
  end

  always @(negedge clk) begin : monitor
    expT e;
    checkOutput("irq", {31'b0, irq_o}, {31'b0, rst_n ? |(mPend & mIe) : 1'b0});
    if (ack_o) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_ack", {31'b0, ack_o}, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("ack_cycle", cyc, e.cyc);
        if (!e.we) checkOutput("rdata", rdata_o, e.data);
      end
    end else begin
      checkOutput("rdata_idle", rdata_o, 32'd0);
      if (expQ.size() != 0 && expQ[0].cyc <= cyc) begin
        e = expQ.pop_front();
        checkOutput("missing_ack", {31'b0, ack_o}, 32'd1);
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] addr, input logic [31:0] data);
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = addr;
    wdata_i = data;
    nextCycle();
    req_i   = 1'b0;
    we_i    = 1'b0;
  endtask

  task automatic readExpect(input string name, input logic [4:0] addr, input logic [31:0] exp);
    applyStimulus(1'b0, addr, 32'd0);
    @(negedge clk);
    checkOutput(name, rdata_o, exp);
    nextCycle();
  endtask

  task automatic resetDut(input logic [NP-1:0] pins);
    rst_n = 1'b0;
    expQ.delete();
    pin_i = pins;
    waitCycles(3);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; pin_i = '0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;

    // Reset with all pins high: no acks, zero data, no interrupt
    pin_i = 8'hFF;
    @(posedge clk); #1;
    for (int a = 0; a < 5; a++) begin
      req_i = 1'b1; addr_i = 5'(a * 4);
      @(negedge clk);
      checkOutput("reset_ack", {31'b0, ack_o}, 32'd0);
      checkOutput("reset_rdata", rdata_o, 32'd0);
      checkOutput("reset_irq", {31'b0, irq_o}, 32'd0);
      nextCycle();
    end
    req_i = 1'b0;
    rst_n = 1'b1;
    applyStimulus(1'b1, 5'h04, 32'hFF);
    waitCycles(10);
    readExpect("reset_pend_after_release", 5'h0C, 32'hFF);

    // Rising edge latency and W1C
    resetDut('0);
    applyStimulus(1'b1, 5'h00, 32'h01);
    applyStimulus(1'b1, 5'h04, 32'h01);
    pin_i[0] = 1'b1;
    repeat (FL + 1) @(posedge clk);
    @(negedge clk);
    checkOutput("rise_irq_early", {31'b0, irq_o}, 32'd0);
    @(negedge clk);
    checkOutput("rise_irq_on_time", {31'b0, irq_o}, 32'd1);
    nextCycle();
    readExpect("rise_pend", 5'h0C, 32'h01);
    applyStimulus(1'b1, 5'h0C, 32'h01);
    @(negedge clk);
    checkOutput("rise_irq_cleared", {31'b0, irq_o}, 32'd0);
    nextCycle();

    // Glitch rejection, then an accepted pulse
    resetDut('0);
    applyStimulus(1'b1, 5'h04, 32'hFF);
    applyStimulus(1'b1, 5'h08, 32'hFF);
    pin_i[3] = 1'b1;
    waitCycles(FL - 1);
    pin_i[3] = 1'b0;
    waitCycles(10);
    readExpect("glitch_pend", 5'h0C, 32'h00);
    readExpect("glitch_level", 5'h10, 32'h00);
    pin_i[3] = 1'b1;
    waitCycles(FL + 2);
    pin_i[3] = 1'b0;
    waitCycles(10);
    readExpect("pulse_pend", 5'h0C, 32'h08);

    // Masked falling edge
    resetDut('0);
    pin_i[7] = 1'b1;
    waitCycles(12);
    applyStimulus(1'b1, 5'h08, 32'h80);
    applyStimulus(1'b1, 5'h00, 32'h00);
    pin_i[7] = 1'b0;
    waitCycles(12);
    readExpect("fall_pend", 5'h0C, 32'h80);
    checkOutput("fall_irq_masked", {31'b0, irq_o}, 32'd0);
    applyStimulus(1'b1, 5'h00, 32'h80);
    @(negedge clk);
    checkOutput("fall_irq_unmasked", {31'b0, irq_o}, 32'd1);
    nextCycle();

    // W1C colliding with a new edge event on the same bit
    resetDut('0);
    applyStimulus(1'b1, 5'h00, 32'h04);
    applyStimulus(1'b1, 5'h04, 32'h04);
    applyStimulus(1'b1, 5'h08, 32'h04);
    pin_i[2] = 1'b1;
    waitCycles(12);
    pin_i[2] = 1'b0;
    waitCycles(FL + 1);
    applyStimulus(1'b1, 5'h0C, 32'h04);
    @(negedge clk);
    checkOutput("collide_irq", {31'b0, irq_o}, 32'd1);
    nextCycle();
    readExpect("collide_pend", 5'h0C, 32'h04);

    // Bus corner cases
    readExpect("unmapped_read", 5'h14, 32'h0);
    applyStimulus(1'b1, 5'h00, 32'hFFFF_FFFF);
    readExpect("ie_width", 5'h00, 32'h0000_00FF);
    applyStimulus(1'b0, 5'h00, 32'h0);
    applyStimulus(1'b0, 5'h10, 32'h0);
    waitCycles(2);

    // Randomised traffic with one mid-run reset
    for (int it = 0; it < 1500; it++) begin
      if (it == 700) begin
        rst_n = 1'b0;
        expQ.delete();
      end
      if (it == 704) rst_n = 1'b1;
      pin_i   = pin_i ^ (NP'($urandom) & NP'($urandom) & NP'($urandom));
      req_i   = $urandom_range(0, 1) == 1;
      we_i    = $urandom_range(0, 2) == 0;
      addr_i  = 5'($urandom);
      wdata_i = $urandom;
      nextCycle();
    end
    req_i = 1'b0;
    we_i  = 1'b0;
    waitCycles(4);
    checkOutput("queue_drained", expQ.size(), 32'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
